rdc_irq_collector: RTL and testbench

Consumer side of the Request Duration Counter interrupt interface. Turns each newly asserted bit of the per-core interruption vector into a timestamped record `{core, event, watermark, timestamp}` and queues it in a FIFO. Software or a bus adapter drains the records through a valid/ready port. The block sits between the RDC and the PMU register/AXI front-end, and gives software an ordered log of offending signals instead of a single sticky flag.

---
 rtl/rdc_irq_collector.sv | 191 +++++++++++++++++++
 tb/tb_rdc_irq_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdc_irq_collector.sv
// rdc_irq_collector: captures rising edges of the RDC interruption vector,
// scans pending bits round-robin and logs {core, event, watermark, timestamp}
// records into a FIFO drained through a valid/ready port.
module rdc_irq_collector #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 2,
  parameter int FIFO_DEPTH    = 8,
  localparam int CORE_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int EVENT_W = (CORE_EVENTS > 1) ? $clog2(CORE_EVENTS) : 1,
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [CORE_EVENTS-1:0]   interruption_vector_i [0:N_CORES-1],
  input  logic [WEIGHTS_WIDTH-1:0] watermark_i [0:N_CORES-1][0:CORE_EVENTS-1],
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [CORE_W-1:0]        rec_core_o,
  output logic [EVENT_W-1:0]       rec_event_o,
  output logic [WEIGHTS_WIDTH-1:0] rec_watermark_o,
  output logic [DATA_WIDTH-1:0]    rec_timestamp_o,
  output logic [CNT_W-1:0]         fifo_count_o,
  output logic                     overflow_o,
  output logic [DATA_WIDTH-1:0]    dropped_count_o,
  output logic                     irq_o
);

  localparam int N     = N_CORES * CORE_EVENTS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N-1:0]             vec_s;
  logic [N-1:0]             prev_r;
  logic [N-1:0]             rise_s;
  logic [N-1:0]             pend_r;
  logic [N-1:0]             sel_mask_s;
  logic [IDX_W-1:0]         rr_r;
  logic [IDX_W-1:0]         rr_next_s;
  logic [IDX_W-1:0]         sel_s;
  logic                     sel_found_s;
  logic [CORE_W-1:0]        sel_core_s;
  logic [EVENT_W-1:0]       sel_event_s;
  logic                     scan_s;
  logic                     pop_s;
  logic                     push_s;
  logic                     drop_s;

  logic [CORE_W-1:0]        core_mem_r  [0:FIFO_DEPTH-1];
  logic [EVENT_W-1:0]       event_mem_r [0:FIFO_DEPTH-1];
  logic [WEIGHTS_WIDTH-1:0] wm_mem_r    [0:FIFO_DEPTH-1];
  logic [DATA_WIDTH-1:0]    ts_mem_r    [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic                     ovf_r;
  logic [DATA_WIDTH-1:0]    drop_cnt_r;
  logic [DATA_WIDTH-1:0]    ts_r;

  // Flatten the per-core vector into index core*CORE_EVENTS+event.
  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    for (genvar e = 0; e < CORE_EVENTS; e++) begin : g_event
      assign vec_s[c*CORE_EVENTS+e] = interruption_vector_i[c][e];
    end
  end

  // Round-robin search for the first pending index at or after rr (wrapping).
  always_comb begin
    sel_s       = '0;
    sel_found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      int   idx;
      logic hit;
      idx         = int'(rr_r) + k;
      idx         = (idx >= N) ? (idx - N) : idx;
      hit         = pend_r[IDX_W'(idx)] & ~sel_found_s;
      sel_s       = hit ? IDX_W'(idx) : sel_s;
      sel_found_s = sel_found_s | hit;
    end
  end

  // Decode the selected index and derive the push/pop/drop decisions.
  always_comb begin
    sel_core_s  = CORE_W'(int'(sel_s) / CORE_EVENTS);
    sel_event_s = EVENT_W'(int'(sel_s) % CORE_EVENTS);
    rr_next_s   = ((int'(sel_s) + 1) >= N) ? '0 : IDX_W'(int'(sel_s) + 1);
    sel_mask_s  = N'(1) << sel_s;
    rise_s      = vec_s & ~prev_r & {N{enable_i}};
    scan_s      = enable_i & sel_found_s & ~clear_i;
    pop_s       = rec_valid_o & rec_ready_i & ~clear_i;
    push_s      = scan_s & ((count_r < CNT_W'(FIFO_DEPTH)) | pop_s);
    drop_s      = scan_s & ~push_s;
  end

  // prev follows the vector every cycle, including while disabled or clearing.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_r <= '0;
    end else begin
      prev_r <= vec_s;
    end
  end

  // Pending set on rises, cleared when scanned; rr advances past each scan.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_r <= '0;
      rr_r   <= '0;
    end else if (clear_i) begin
      pend_r <= '0;
      rr_r   <= '0;
    end else if (scan_s) begin
      pend_r <= (pend_r & ~sel_mask_s) | rise_s;
      rr_r   <= rr_next_s;
    end else begin
      pend_r <= pend_r | rise_s;
    end
  end

  // Record storage; contents are only visible through the masked head port.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      core_mem_r[wr_ptr_r]  <= sel_core_s;
      event_mem_r[wr_ptr_r] <= sel_event_s;
      wm_mem_r[wr_ptr_r]    <= watermark_i[sel_core_s][sel_event_s];
      ts_mem_r[wr_ptr_r]    <= ts_r;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow, saturating drop counter and the gated timestamp.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= '0;
      ts_r       <= '0;
    end else if (clear_i) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= '0;
      ts_r       <= '0;
    end else begin
      if (drop_s) begin
        ovf_r <= 1'b1;
        if (drop_cnt_r != '1) begin
          drop_cnt_r <= drop_cnt_r + DATA_WIDTH'(1);
        end
      end
      if (enable_i) begin
        ts_r <= ts_r + DATA_WIDTH'(1);
      end
    end
  end

  assign rec_valid_o     = (count_r != '0);
  assign rec_core_o      = rec_valid_o ? core_mem_r[rd_ptr_r]  : '0;
  assign rec_event_o     = rec_valid_o ? event_mem_r[rd_ptr_r] : '0;
  assign rec_watermark_o = rec_valid_o ? wm_mem_r[rd_ptr_r]    : '0;
  assign rec_timestamp_o = rec_valid_o ? ts_mem_r[rd_ptr_r]    : '0;
  assign fifo_count_o    = count_r;
  assign overflow_o      = ovf_r;
  assign dropped_count_o = drop_cnt_r;
  assign irq_o           = rec_valid_o | ovf_r;

endmodule

// File: tb/tb_rdc_irq_collector.sv
// Self-checking bench for rdc_irq_collector: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_rdc_irq_collector;

  localparam int NC = 4;
  localparam int CE = 2;
  localparam int N  = NC * CE;
  localparam int IW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic ready = 1'b0;
  logic [N-1:0] vflat = '0;
  logic [7:0]   wflat [0:N-1];
  logic [CE-1:0] vec [0:NC-1];
  logic [7:0]    wm  [0:NC-1][0:CE-1];

  logic        rec_valid;
  logic [1:0]  rec_core;
  logic [0:0]  rec_event;
  logic [7:0]  rec_wm;
  logic [31:0] rec_ts;
  logic [3:0]  fifo_count;
  logic        ovf;
  logic [31:0] dropped;
  logic        irq;

  for (genvar c = 0; c < NC; c++) begin : g_c
    for (genvar e = 0; e < CE; e++) begin : g_e
      assign vec[c][e] = vflat[c*CE+e];
      assign wm[c][e]  = wflat[c*CE+e];
    end
  end

  rdc_irq_collector dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .clear_i(clear),
    .interruption_vector_i(vec), .watermark_i(wm),
    .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_core_o(rec_core),
    .rec_event_o(rec_event), .rec_watermark_o(rec_wm), .rec_timestamp_o(rec_ts),
    .fifo_count_o(fifo_count), .overflow_o(ovf), .dropped_count_o(dropped),
    .irq_o(irq)
  );

  initial forever #5 clk = ~clk;

  // Reference model: pending set, rr pointer, record queue, counters.
  typedef struct packed {
    logic [1:0]  core;
    logic        ev;
    logic [7:0]  wm;
    logic [31:0] ts;
  } rec_t;

  rec_t        mq[$];
  logic [N-1:0] mpend;
  logic [N-1:0] mprev;
  int          mrr;
  logic        movf;
  logic [31:0] mdrop;
  logic [31:0] mts;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    mpend = '0; mprev = '0; mrr = 0; movf = 1'b0; mdrop = '0; mts = '0;
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge.
  task automatic model_step();
    bit   pop, full;
    int   sel;
    rec_t r;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (clear) begin
      mq.delete();
      mpend = '0; mrr = 0; movf = 1'b0; mdrop = '0; mts = '0;
      mprev = vflat;
      return;
    end
    pop  = (mq.size() > 0) && ready;
    full = (mq.size() >= DEPTH);
    sel  = -1;
    if (enable && mpend != '0) begin
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && mpend[IW'((mrr + k) % N)]) sel = (mrr + k) % N;
      end
      r.core = 2'(sel / CE);
      r.ev   = 1'(sel % CE);
      r.wm   = wflat[IW'(sel)];
      r.ts   = mts;
      mpend[IW'(sel)] = 1'b0;
      mrr = (sel + 1) % N;
    end
    if (pop) void'(mq.pop_front());
    if (sel >= 0) begin
      if (!full || pop) mq.push_back(r);
      else begin
        movf = 1'b1;
        if (mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 32'd1;
      end
    end
    if (enable) begin
      mpend = mpend | (vflat & ~mprev);
      mts = mts + 32'd1;
    end
    mprev = vflat;
  endtask

  // Advance one clock: model follows the edge, return at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare process: every negedge, DUT outputs versus the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      rec_t h;
      bit   v;
      v = (mq.size() != 0);
      h = v ? mq[0] : '0;
      chk("valid",   64'(rec_valid),  64'(v));
      chk("core",    64'(rec_core),   64'(h.core));
      chk("event",   64'(rec_event),  64'(h.ev));
      chk("wm",      64'(rec_wm),     64'(h.wm));
      chk("ts",      64'(rec_ts),     64'(h.ts));
      chk("count",   64'(fifo_count), 64'(mq.size()));
      chk("ovf",     64'(ovf),        64'(movf));
      chk("dropped", 64'(dropped),    64'(mdrop));
      chk("irq",     64'(irq),        64'(v | movf));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) wflat[i] = 8'(i * 17);
    model_reset();
    repeat (3) cycle();
    rstn = 1'b1;
    chk_en = 1'b1;

    // Idle with enable low: all zero.
    repeat (5) cycle();
    chk("idle_valid", 64'(rec_valid), 64'd0);
    chk("idle_count", 64'(fifo_count), 64'd0);
    chk("idle_irq",   64'(irq), 64'd0);

    // Single rise at enabled cycle 10 on core 2 event 1.
    enable = 1'b1;
    repeat (10) cycle();
    vflat[5] = 1'b1;
    wflat[5] = 8'h23;
    ready = 1'b1;
    cycle();
    cycle();
    chk("single_valid", 64'(rec_valid), 64'd1);
    chk("single_core",  64'(rec_core), 64'd2);
    chk("single_event", 64'(rec_event), 64'd1);
    chk("single_wm",    64'(rec_wm), 64'h23);
    chk("single_ts",    64'(rec_ts), 64'd11);
    cycle();
    chk("single_gone", 64'(rec_valid), 64'd0);
    repeat (4) cycle();
    chk("held_no_rec", 64'(fifo_count), 64'd0);

    // Burst of 8 rises into an empty FIFO with ready low.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    vflat = '0;
    ready = 1'b0;
    cycle();
    vflat = '1;
    repeat (10) cycle();
    chk("burst_count", 64'(fifo_count), 64'd8);
    chk("burst_core0", 64'(rec_core), 64'd0);
    chk("burst_ev0",   64'(rec_event), 64'd0);
    chk("burst_noovf", 64'(ovf), 64'd0);
    vflat[0] = 1'b0;
    cycle();
    vflat[0] = 1'b1;
    cycle();
    cycle();
    chk("drop_ovf",   64'(ovf), 64'd1);
    chk("drop_cnt",   64'(dropped), 64'd1);
    chk("drop_count", 64'(fifo_count), 64'd8);

    // Full FIFO: push and pop in the same cycle.
    vflat[1] = 1'b0;
    cycle();
    vflat[1] = 1'b1;
    cycle();
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    chk("fullpp_count", 64'(fifo_count), 64'd8);
    chk("fullpp_drop",  64'(dropped), 64'd1);
    chk("fullpp_ev",    64'(rec_event), 64'd1);

    // Enable low with 3 pending bits.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    vflat = '0;
    cycle();
    vflat = 8'b0010_0110;
    cycle();
    enable = 1'b0;
    repeat (4) cycle();
    chk("dis_count", 64'(fifo_count), 64'd0);
    enable = 1'b1;
    cycle();
    chk("reen_count1", 64'(fifo_count), 64'd1);
    chk("reen_ts",     64'(rec_ts), 64'd2);
    chk("reen_ev",     64'(rec_event), 64'd1);
    cycle();
    chk("reen_count2", 64'(fifo_count), 64'd2);
    cycle();
    chk("reen_count3", 64'(fifo_count), 64'd3);

    // Clear with entries present and a push in progress.
    vflat = '0;
    cycle();
    vflat = 8'hF0;
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clr_count", 64'(fifo_count), 64'd0);
    chk("clr_valid", 64'(rec_valid), 64'd0);
    chk("clr_ovf",   64'(ovf), 64'd0);
    chk("clr_drop",  64'(dropped), 64'd0);

    // Asynchronous reset in the middle of a burst.
    vflat = '0;
    cycle();
    vflat = '1;
    repeat (3) cycle();
    rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(rec_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_irq",   64'(irq), 64'd0);
    cycle();
    rstn = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) vflat[IW'(i)] = ~vflat[IW'(i)];
        wflat[i] = 8'($urandom);
      end
      ready  = ((c / 300) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      enable = ($urandom_range(15) != 0);
      clear  = ($urandom_range(249) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
